// File: rtl/pipe_shift_unit.sv
// Pipelined logarithmic shift/rotate unit with valid/ready handshake, flush and tag pass-through.
// Define SHIFT_FLAGS_EN to build the registered out_zero/out_carry flags; otherwise both are tied low.
module pipe_shift_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic                     out_zero,
  output logic                     out_carry,
  output logic                     busy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CHUNK   = (SHAMT_W + STAGES - 1) / STAGES;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;

  function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] d,
                                                  input logic [2:0] op, input int k);
    case (op)
      OP_SLL:  step_shift = d << k;
      OP_SRL:  step_shift = d >> k;
      OP_SRA:  step_shift = $unsigned($signed(d) >>> k);
      OP_ROL:  step_shift = (d << k) | (d >> (WIDTH - k));
      OP_ROR:  step_shift = (d >> k) | (d << (WIDTH - k));
      default: step_shift = d;
    endcase
  endfunction

`ifdef SHIFT_FLAGS_EN
  // Bit leaving the word in this sub-step; the last non-zero sub-step wins.
  function automatic logic step_carry(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                      input int k, input logic c);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    case (op)
      OP_SLL:         step_carry = |(d & (one << (WIDTH - k)));
      OP_SRL, OP_SRA: step_carry = |(d & (one << (k - 1)));
      default:        step_carry = c;
    endcase
  endfunction

  logic [STAGES-1:0] carry_q;
`endif

  logic [STAGES-1:0]              vld_q;
  logic [STAGES-1:0][WIDTH-1:0]   data_q;
  logic [STAGES-1:0][2:0]         op_q;
  logic [STAGES-1:0][SHAMT_W-1:0] shamt_q;
  logic [STAGES-1:0][TAG_W-1:0]   tag_q;
  logic [STAGES-1:0]              err_q;

  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_err_q;
  logic             advance;

  assign advance  = ~out_vld_q | out_ready;
  assign in_ready = advance & ~rst & ~flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * CHUNK;
    localparam int HI = (s == STAGES - 1) ? SHAMT_W
                      : ((LO + CHUNK > SHAMT_W) ? SHAMT_W : LO + CHUNK);

    logic               src_vld_s;
    logic               src_err_s;
    logic [WIDTH-1:0]   src_data_s;
    logic [2:0]         src_op_s;
    logic [SHAMT_W-1:0] src_shamt_s;
    logic [TAG_W-1:0]   src_tag_s;
    logic [WIDTH-1:0]   data_d;
`ifdef SHIFT_FLAGS_EN
    logic               src_carry_s;
    logic               carry_d;
`endif

    if (s == 0) begin : g_src
      // PASS and illegal ops enter with a zero shift so every stage leaves them untouched.
      logic illegal_s;
      assign illegal_s   = (in_op[2:1] == 2'b11);
      assign src_vld_s   = in_valid & in_ready;
      assign src_err_s   = illegal_s;
      assign src_data_s  = illegal_s ? {WIDTH{1'b0}} : in_data;
      assign src_op_s    = in_op;
      assign src_shamt_s = (illegal_s || in_op == OP_PASS) ? {SHAMT_W{1'b0}} : in_shamt;
      assign src_tag_s   = in_tag;
`ifdef SHIFT_FLAGS_EN
      assign src_carry_s = 1'b0;
`endif
    end else begin : g_src
      assign src_vld_s   = vld_q[s-1];
      assign src_err_s   = err_q[s-1];
      assign src_data_s  = data_q[s-1];
      assign src_op_s    = op_q[s-1];
      assign src_shamt_s = shamt_q[s-1];
      assign src_tag_s   = tag_q[s-1];
`ifdef SHIFT_FLAGS_EN
      assign src_carry_s = carry_q[s-1];
`endif
    end

    always_comb begin
      data_d = src_data_s;
`ifdef SHIFT_FLAGS_EN
      carry_d = src_carry_s;
`endif
      for (int i = 0; i < SHAMT_W; i++) begin
        if (i >= LO && i < HI &&
            |(src_shamt_s & ({{(SHAMT_W-1){1'b0}}, 1'b1} << i))) begin
`ifdef SHIFT_FLAGS_EN
          carry_d = step_carry(data_d, src_op_s, 1 << i, carry_d);
`endif
          data_d = step_shift(data_d, src_op_s, 1 << i);
        end else begin
          data_d = data_d;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s]   <= 1'b0;
        err_q[s]   <= 1'b0;
        data_q[s]  <= {WIDTH{1'b0}};
        op_q[s]    <= 3'b000;
        shamt_q[s] <= {SHAMT_W{1'b0}};
        tag_q[s]   <= {TAG_W{1'b0}};
`ifdef SHIFT_FLAGS_EN
        carry_q[s] <= 1'b0;
`endif
      end else if (flush) begin
        vld_q[s] <= 1'b0;
      end else if (advance) begin
        vld_q[s]   <= src_vld_s;
        err_q[s]   <= src_err_s;
        data_q[s]  <= data_d;
        op_q[s]    <= src_op_s;
        shamt_q[s] <= src_shamt_s;
        tag_q[s]   <= src_tag_s;
`ifdef SHIFT_FLAGS_EN
        carry_q[s] <= carry_d;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= {WIDTH{1'b0}};
      out_tag_q  <= {TAG_W{1'b0}};
      out_err_q  <= 1'b0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (advance) begin
      out_vld_q  <= vld_q[STAGES-1];
      out_data_q <= data_q[STAGES-1];
      out_tag_q  <= tag_q[STAGES-1];
      out_err_q  <= err_q[STAGES-1];
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic out_zero_q;
  logic out_carry_q;
  logic out_carry_d;

  // Rotates report the bit that wrapped around, which is only known once the full result exists.
  always_comb begin
    out_carry_d = carry_q[STAGES-1];
    if (shamt_q[STAGES-1] != {SHAMT_W{1'b0}}) begin
      case (op_q[STAGES-1])
        OP_ROL:  out_carry_d = data_q[STAGES-1][0];
        OP_ROR:  out_carry_d = data_q[STAGES-1][WIDTH-1];
        default: out_carry_d = carry_q[STAGES-1];
      endcase
    end else begin
      out_carry_d = carry_q[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_zero_q  <= 1'b0;
      out_carry_q <= 1'b0;
    end else if (advance && !flush) begin
      out_zero_q  <= (data_q[STAGES-1] == {WIDTH{1'b0}});
      out_carry_q <= out_carry_d;
    end
  end

  assign out_zero  = out_zero_q;
  assign out_carry = out_carry_q;
`else
  logic unused_s;
  assign unused_s  = ^{op_q[STAGES-1], shamt_q[STAGES-1]};
  assign out_zero  = 1'b0;
  assign out_carry = 1'b0;
`endif

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
  assign busy      = (|vld_q) | out_vld_q;

endmodule

// File: tb/tb_pipe_shift_unit.sv
// Directed bench for pipe_shift_unit: three instances (STAGES=2, 1, 5) with hand-computed results.
module tb_pipe_shift_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, out_ready, v1, v2, v5;
  logic [2:0] in_op;
  logic [W-1:0] in_data;
  logic [4:0] in_shamt;
  logic [3:0] in_tag;

  logic ir1, ov1, oe1, oz1, oc1, bz1;
  logic ir2, ov2, oe2, oz2, oc2, bz2;
  logic ir5, ov5, oe5, oz5, oc5, bz5;
  logic [W-1:0] od1, od2, od5;
  logic [3:0] ot1, ot2, ot5;

  pipe_shift_unit #(.WIDTH(W), .STAGES(2), .TAG_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v2), .in_ready(ir2), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag), .out_valid(ov2),
    .out_ready(out_ready), .out_data(od2), .out_tag(ot2), .out_err(oe2),
    .out_zero(oz2), .out_carry(oc2), .busy(bz2));

  pipe_shift_unit #(.WIDTH(W), .STAGES(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v1), .in_ready(ir1), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1), .out_tag(ot1), .out_err(oe1),
    .out_zero(oz1), .out_carry(oc1), .busy(bz1));

  pipe_shift_unit #(.WIDTH(W), .STAGES(5), .TAG_W(4)) u_dut5 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v5), .in_ready(ir5), .in_op(in_op),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag), .out_valid(ov5),
    .out_ready(out_ready), .out_data(od5), .out_tag(ot5), .out_err(oe5),
    .out_zero(oz5), .out_carry(oc5), .busy(bz5));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c,
                             input logic ez, input logic ec);
`ifdef SHIFT_FLAGS_EN
    check({tag, "_zero"}, z, ez);
    check({tag, "_carry"}, c, ec);
`else
    check({tag, "_zero"}, z, 1'b0);
    check({tag, "_carry"}, c, 1'b0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue2(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [3:0] tg);
    in_op = op; in_data = d; in_shamt = sh; in_tag = tg; v2 = 1'b1;
    #1;
    check("issue_ready", ir2, 1'b1);
    tick();
    v2 = 1'b0;
  endtask

  task automatic expect2(input string tag, input logic [31:0] d, input logic [3:0] tg,
                         input logic err, input logic z, input logic c);
    check({tag, "_valid"}, ov2, 1'b1);
    check({tag, "_data"}, od2, d);
    check({tag, "_tag"}, ot2, tg);
    check({tag, "_err"}, oe2, err);
    check_flags(tag, oz2, oc2, z, c);
  endtask

  logic [2:0]  bp_op  [4];
  logic [31:0] bp_in  [4];
  logic [4:0]  bp_sh  [4];
  logic [31:0] bp_exp [4];
  logic        bp_err [4];

  initial begin
    int n_in, n_out, stall, seen;
    int lat1, lat5;
    logic acc, first_seen;
    logic [31:0] d1, d5;

    bp_op[0] = 3'b000; bp_in[0] = 32'h0000_0001; bp_sh[0] = 5'd1; bp_exp[0] = 32'h0000_0002; bp_err[0] = 1'b0;
    bp_op[1] = 3'b001; bp_in[1] = 32'h0000_0080; bp_sh[1] = 5'd3; bp_exp[1] = 32'h0000_0010; bp_err[1] = 1'b0;
    bp_op[2] = 3'b101; bp_in[2] = 32'hdead_beef; bp_sh[2] = 5'd7; bp_exp[2] = 32'hdead_beef; bp_err[2] = 1'b0;
    bp_op[3] = 3'b111; bp_in[3] = 32'h0000_0055; bp_sh[3] = 5'd2; bp_exp[3] = 32'h0000_0000; bp_err[3] = 1'b1;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; v1 = 1'b0; v2 = 1'b0; v5 = 1'b0;
    in_op = 3'b000; in_data = 32'h0; in_shamt = 5'd0; in_tag = 4'd0;
    tick(); tick();
    check("rst_valid", ov2, 1'b0);
    check("rst_data", od2, 32'h0);
    check("rst_busy", bz2, 1'b0);
    check("rst_ready", ir2, 1'b0);
    check_flags("rst", oz2, oc2, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Single SLL: two cycles of latency
    issue2(3'b000, 32'h0000_7fff, 5'd4, 4'd5);
    check("sll_busy", bz2, 1'b1);
    check("sll_early0", ov2, 1'b0);
    tick();
    check("sll_early1", ov2, 1'b0);
    tick();
    expect2("sll", 32'h0007_fff0, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    check("sll_drained", ov2, 1'b0);

    // SRA then SRL back-to-back
    issue2(3'b010, 32'h8000_0000, 5'd31, 4'd1);
    issue2(3'b001, 32'h8000_0000, 5'd31, 4'd2);
    check("sra_early", ov2, 1'b0);
    tick();
    expect2("sra", 32'hffff_ffff, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    expect2("srl", 32'h0000_0001, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();

    // ROR by 8, ROL by 0
    issue2(3'b100, 32'h1234_abcd, 5'd8, 4'd3);
    issue2(3'b011, 32'h4470_7fff, 5'd0, 4'd4);
    tick();
    expect2("ror", 32'hcd12_34ab, 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    expect2("rol0", 32'h4470_7fff, 4'd4, 1'b0, 1'b0, 1'b0);
    tick();

    // Backpressure: out_ready low for 3 cycles once the first result appears
    n_in = 0; n_out = 0; stall = 0; first_seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (n_out == 4) break;
      if (ov2 && !first_seen) begin
        first_seen = 1'b1;
        stall = 3;
      end
      out_ready = (stall == 0);
      if (n_in < 4) begin
        v2 = 1'b1; in_op = bp_op[n_in]; in_data = bp_in[n_in];
        in_shamt = bp_sh[n_in]; in_tag = 4'(n_in + 1);
      end else begin
        v2 = 1'b0;
      end
      #1;
      if (stall > 0) begin
        check("bp_ready_low", ir2, 1'b0);
        check("bp_hold_valid", ov2, 1'b1);
        check("bp_hold_data", od2, bp_exp[0]);
        check("bp_hold_tag", ot2, 4'd1);
        stall--;
      end
      if (ov2 && out_ready) begin
        check("bp_data", od2, bp_exp[n_out]);
        check("bp_tag", ot2, 4'(n_out + 1));
        check("bp_err", oe2, bp_err[n_out]);
        n_out++;
      end
      acc = v2 & ir2;
      tick();
      if (acc) n_in++;
    end
    v2 = 1'b0; out_ready = 1'b1;
    check("bp_delivered", n_out, 4);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (ov2) seen++;
      tick();
    end
    check("bp_no_dup", seen, 0);

    // Reset with two ops in flight on the 2- and 5-stage units
    in_op = 3'b000; in_data = 32'h0000_0003; in_shamt = 5'd1; in_tag = 4'd7;
    v2 = 1'b1; v5 = 1'b1;
    tick();
    in_tag = 4'd8;
    tick();
    v2 = 1'b0; v5 = 1'b0; rst = 1'b1;
    #1;
    check("rstmid_pre_valid", ov2, 1'b0);
    tick();
    check("rstmid_valid", ov2, 1'b0);
    check("rstmid_data", od2, 32'h0);
    check("rstmid_tag", ot2, 4'd0);
    check("rstmid_err", oe2, 1'b0);
    check("rstmid_busy", bz2, 1'b0);
    check("rstmid_busy5", bz5, 1'b0);
    check_flags("rstmid", oz2, oc2, 1'b0, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ov2 || ov5) seen++;
    end
    check("rstmid_never", seen, 0);

    // Latency equals STAGES for the 1- and 5-stage units
    in_op = 3'b011; in_data = 32'h8000_0001; in_shamt = 5'd17; in_tag = 4'd3;
    v1 = 1'b1; v5 = 1'b1;
    #1;
    tick();
    v1 = 1'b0; v5 = 1'b0;
    lat1 = 0; lat5 = 0; d1 = 32'h0; d5 = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ov1 && lat1 == 0) begin lat1 = k; d1 = od1; end
      if (ov5 && lat5 == 0) begin lat5 = k; d5 = od5; end
    end
    check("lat_s1", lat1, 1);
    check("lat_s5", lat5, 5);
    check("rol17_s1", d1, 32'h0003_0000);
    check("rol17_s5", d5, 32'h0003_0000);
    check("tag_s5", ot5, 4'd3);

    // Flush with two ops in flight and a request pending
    issue2(3'b000, 32'h0000_0001, 5'd2, 4'd1);
    issue2(3'b001, 32'h0000_0100, 5'd2, 4'd2);
    flush = 1'b1; v2 = 1'b1; in_op = 3'b101; in_data = 32'h0000_00aa; in_tag = 4'd3;
    #1;
    check("flush_ready", ir2, 1'b0);
    tick();
    flush = 1'b0; v2 = 1'b0;
    check("flush_busy", bz2, 1'b0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (ov2) seen++;
      tick();
    end
    check("flush_never", seen, 0);
    issue2(3'b110, 32'h0000_1234, 5'd3, 4'd9);
    tick();
    tick();
    expect2("illegal", 32'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
